// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-add multiplier: N iterations per product, plus a hex
// seven-segment view of the result. Signed operands via SHIFT_ADD_MULTIPLIER_SIGNED_EN.
module shift_add_multiplier #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
  input  logic             signedMode,
`endif
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product,
  output logic [7*N/2-1:0] productDisp
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N:0]     sum;
  logic [N-1:0]   a_mag, b_mag;
  logic [2*N-1:0] res;
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
  logic           neg_q, neg_d;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    sum       = '0;
    res       = '0;
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
    neg_d     = neg_q;
    // Iterate on magnitudes; the sign is reapplied once at the end.
    a_mag     = (signedMode && a[N-1]) ? (~a + 1'b1) : a;
    b_mag     = (signedMode && b[N-1]) ? (~b + 1'b1) : b;
`else
    a_mag     = a;
    b_mag     = b;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
          neg_d    = signedMode && (a[N-1] ^ b[N-1]);
`endif
        end
      end
      RUN: begin
        sum      = acc_q[2*N:N] + {1'b0, mcand_q & {N{mplier_q[0]}}};
        acc_d    = (2*N+1)'({sum, acc_q[N-1:0]} >> 1);
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          res = acc_d[2*N-1:0];
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
          if (neg_q) res = ~res + 1'b1;
`endif
          product_d = res;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

  // Segment order {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction

  for (genvar k = 0; k < N/2; k++) begin : g_disp
    assign productDisp[7*k +: 7] = hex7(product_q[4*k +: 4]);
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier at N=4 and N=8.
module tb_shift_add_multiplier;

  logic        clk, resetN;
  logic [3:0]  a4, b4;
  logic        start4, busy4, done4, sm4;
  logic [7:0]  prod4;
  logic [13:0] disp4;
  logic [7:0]  a8, b8;
  logic        start8, busy8, done8, sm8;
  logic [15:0] prod8;
  logic [27:0] disp8;

  int checks = 0;
  int failures = 0;
  logic [7:0]  q4[$];
  logic [15:0] q8[$];
  logic [7:0]  last4 = '0;

  shift_add_multiplier #(.N(4)) u_dut4 (
    .clk(clk), .resetN(resetN), .a(a4), .b(b4),
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
    .signedMode(sm4),
`endif
    .start(start4), .busy(busy4), .done(done4), .product(prod4), .productDisp(disp4)
  );

  shift_add_multiplier #(.N(8)) u_dut8 (
    .clk(clk), .resetN(resetN), .a(a8), .b(b8),
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
    .signedMode(sm8),
`endif
    .start(start8), .busy(busy8), .done(done8), .product(prod8), .productDisp(disp8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[v];
  endfunction

  // Waits for done starting from 'edges' edges after capture; pops and checks.
  task automatic finish4(input int edges0);
    int edges;
    logic [7:0] e;
    edges = edges0;
    while (!done4 && edges < 20) begin
      chk("busy_run", busy4, 1);
      chk("hold_run", prod4, last4);
      @(negedge clk);
      edges++;
    end
    chk("latency4", edges, 5);
    chk("busy_done", busy4, 0);
    e = q4.pop_front();
    chk("product4", prod4, e);
    chk("disp4", disp4, {seg(e[7:4]), seg(e[3:0])});
    last4 = e;
  endtask

  task automatic mul4(input logic [3:0] x, input logic [3:0] y, input logic s);
    int sx, sy, p;
    sx = (s && x[3]) ? int'(x) - 16 : int'(x);
    sy = (s && y[3]) ? int'(y) - 16 : int'(y);
    p  = sx * sy;
    @(negedge clk);
    a4 = x; b4 = y; sm4 = s; start4 = 1'b1;
    q4.push_back(p[7:0]);
    @(negedge clk);
    start4 = 1'b0;
    a4 = ~x; b4 = ~y; sm4 = ~s;   // must not disturb the run in flight
    finish4(1);
  endtask

  task automatic mul8(input logic [7:0] x, input logic [7:0] y);
    int edges;
    logic [15:0] e;
    @(negedge clk);
    a8 = x; b8 = y; start8 = 1'b1;
    q8.push_back({8'h0, x} * {8'h0, y});
    @(negedge clk);
    start8 = 1'b0; a8 = ~x;
    edges = 1;
    while (!done8 && edges < 30) begin
      chk("busy8_run", busy8, 1);
      @(negedge clk);
      edges++;
    end
    chk("latency8", edges, 9);
    e = q8.pop_front();
    chk("product8", prod8, e);
  endtask

  initial begin
    int edges;
    resetN = 1'b0; start4 = 0; start8 = 0; sm4 = 0; sm8 = 0;
    a4 = 0; b4 = 0; a8 = 0; b8 = 0;
    #1;
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_prod", prod4, 0);
    chk("rst_disp", disp4, {seg(4'h0), seg(4'h0)});
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;

    mul4(4'hF, 4'hF, 1'b0);
    chk("disp_e1", disp4, {7'h79, 7'h06});
    mul4(4'h0, 4'h9, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("done_persist", done4, 1);
      chk("prod_persist", prod4, last4);
    end

    // start held high: restart straight from DONE, ignored during RUN
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
    q4.push_back(8'd15);
    @(negedge clk);
    finish4(1);
    q4.push_back(8'd15);
    @(negedge clk);
    chk("restart_done", done4, 0);
    chk("restart_busy", busy4, 1);
    start4 = 1'b0;
    finish4(1);

    // reset mid-run aborts without a partial result
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hF; start4 = 1'b1;
    q4.push_back(8'hE1);
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    #2 resetN = 1'b0;
    #1;
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    chk("abort_prod", prod4, 0);
    chk("abort_disp", disp4, {seg(4'h0), seg(4'h0)});
    q4.delete();
    last4 = '0;
    @(negedge clk);
    resetN = 1'b1; a4 = 4'd2; b4 = 4'd7; start4 = 1'b1;
    q4.push_back(8'd14);
    @(negedge clk);
    start4 = 1'b0;
    finish4(1);

    repeat (6) mul4(4'($urandom), 4'($urandom), 1'b0);

    mul8(8'hFF, 8'hFF);
    mul8(8'h00, 8'h80);
    repeat (3) mul8(8'($urandom), 8'($urandom));

`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
    mul4(4'h8, 4'h7, 1'b1);
    mul4(4'h8, 4'h8, 1'b1);
    mul4(4'hF, 4'h3, 1'b1);
    mul4(4'h8, 4'h8, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The module SHALL have parameter N, default 4, giving the operand width in bits; N SHALL be a multiple of 2 and at least 4.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port resetN, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port a, input, N bits: multiplicand.
REQ-005 The module SHALL have port b, input, N bits: multiplier.
REQ-006 The module SHALL have port start, input, 1 bit: request to begin a multiply; it is sampled on each rising edge.
REQ-007 The module SHALL have port busy, output, 1 bit: a multiply is in progress.
REQ-008 The module SHALL have port done, output, 1 bit: product holds a completed result.
REQ-009 The module SHALL have port product, output, 2N bits: last completed result.
REQ-010 The module SHALL have port productDisp, output, 7N/2 bits: seven-segment codes for the N/2 hex digits of product.

Function
REQ-011 The block SHALL be a radix-2 shift-add multiplier with three states: IDLE, RUN, DONE.
REQ-012 On a rising edge in IDLE or DONE with start=1, the block SHALL:
- capture a and b into internal registers;
- clear the accumulator and the iteration counter;
- enter RUN.
REQ-013 In RUN, each rising edge SHALL perform one iteration:
- if the current multiplier LSB is 1, add the multiplicand to the upper N+1 accumulator bits;
- shift the accumulator right by one;
- increment the counter.
REQ-014 After exactly N RUN iterations, the block SHALL load product from the accumulator and enter DONE. Latency is N+1 rising edges from the start-sampling edge to done=1.
REQ-015 busy SHALL be 1 exactly while the state is RUN.
REQ-016 done SHALL be 1 exactly while the state is DONE; DONE SHALL persist until start=1 or reset.
REQ-017 start=1 while in RUN SHALL be ignored, with no effect on the operands, the counter or the result.
REQ-018 Changes to a or b after the capture edge SHALL NOT affect the result in progress.
REQ-019 product SHALL change only on entry to DONE and SHALL hold its previous value throughout RUN.
REQ-020 Arithmetic SHALL be exact over 2N bits: the maximum (2^N-1)^2 SHALL fit without overflow, and a zero operand SHALL still take the full N iterations.
REQ-021 productDisp digit k, occupying bits [7k+6:7k], SHALL be the team hex display decoder output for product[4k+3:4k], for k = 0 .. N/2-1; it SHALL be purely combinational from product.

Reset
REQ-022 When resetN=0, the block SHALL immediately, without waiting for a clock edge, go to IDLE and clear product, the accumulator, the counter and the operand registers; busy and done SHALL be 0.
REQ-023 productDisp SHALL show digit 0 in every position while in reset.
REQ-024 Reset asserted during RUN SHALL abort the operation, leaving no partial result in product; after release, the block SHALL wait in IDLE for start.
REQ-025 A start asserted on the first rising edge after resetN rises SHALL be honoured.

Configuration
REQ-026 The block SHALL support macro SHIFT_ADD_MULTIPLIER_SIGNED_EN.
- When the macro is defined: the block SHALL add input port signedMode (1 bit), captured together with a and b. When signedMode=1, operands are two's complement; the block SHALL multiply the magnitudes and negate the 2N-bit result on entry to DONE when the operand signs differ. Latency SHALL remain N+1 edges, and -2^(N-1) x -2^(N-1) SHALL yield +2^(2N-2).
- When the macro is undefined: signedMode SHALL be absent and operation SHALL be unsigned only, with no extra logic.

Verification
REQ-027 N=4: a=15, b=15, one-cycle start -> busy=1 for 4 edges; done=1 on the 5th edge; product=0x00E1; productDisp digits 1, E.
REQ-028 N=4: a=0, b=9 -> done after 5 edges with product=0; the previous non-zero product is held during RUN.
REQ-029 N=4: start held high continuously, a=3, b=5 -> product=15; a new run starts immediately from DONE; pulses during RUN cause no restart.
REQ-030 N=4: resetN low on the 2nd RUN edge -> busy=0, done=0 and product=0 immediately; then start with a=2, b=7 -> product=14.
REQ-031 N=8: a=255, b=255 -> product=0xFE01 after 9 edges.
REQ-032 Signed macro defined, N=4, signedMode=1: a=-8, b=7 -> product=0xC8; a=-8, b=-8 -> product=0x40.
